branch_target_predictor: RTL
============================

Name: branch_target_predictor

Overview:
- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry, indexed by PC.
- IF presents the fetch PC and receives a taken/not-taken prediction plus the next-fetch address in the same cycle.
- EX writes back the resolved branch outcome to train the counters and install or refresh targets.
- Sits between the PC-select mux (consumer of pred_* outputs) and EX branch resolution (producer of upd_*).

Parameters:
- IDX_BITS, 4, log2 of entry count (16 entries); index = pc[IDX_BITS+1:2].
- TAG_BITS, 8, tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- ADDR_W, 32, PC/target width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch lookup is valid this cycle.
- if_pc  in  ADDR_W  fetch PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  next fetch address.
- upd_en  in  1  EX resolved a branch this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome: 1 = taken.
- upd_target  in  ADDR_W  actual taken target.
- upd_mispredict  in  1  EX detected a mispredict (statistics only).

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (ADDR_W), ctr (2). Encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.
- Reset (async, rst=1): every valid=0, every ctr=01, target and tag=0.
- Outputs during reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Lookup is combinational, zero latency:
  - pred_hit = if_valid & valid[idx] & (tag[idx]==if_tag).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, computed mod 2^ADDR_W, so wrap-around at 0xFFFFFFFC gives 0.
- When if_valid=0: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Update is registered on posedge clk when upd_en=1:
  - Tag hit, ctr saturating step:
    - taken: 00->01->10->11, 11 stays 11.
    - not taken: 11->10->01->00, 00 stays 00.
  - Tag hit and upd_taken=1: target <= upd_target.
  - Tag hit and upd_taken=0: target unchanged.
  - Miss (invalid entry or tag mismatch) and upd_taken=1: allocate/replace. valid<=1, tag<=upd tag, target<=upd_target, ctr<=10.
  - Miss and upd_taken=0: no state change; no allocation for not-taken branches.
- No update when upd_en=0.
- Read/write collision: a lookup and an update to the same index in one cycle return the pre-update entry. The write is visible from the next cycle; there is no bypass.
- Only one update per cycle; updates to different indices in consecutive cycles are independent.
- Mid-operation reset: clears all entries immediately; an update coincident with rst is dropped.

Optional Feature:
- Macro: BTP_STATS_EN.
- Defined, adds three 32-bit wrapping counters as outputs: stat_lookups, stat_hits, stat_mispredicts.
  - stat_lookups increments when if_valid=1.
  - stat_hits increments when pred_hit=1.
  - stat_mispredicts increments when upd_en & upd_mispredict.
  - Adds input stat_clr: synchronous clear with priority over increment.
  - All three counters are reset to 0 by rst.
  - 0xFFFFFFFF+1 wraps to 0.
- Undefined: those ports and counters do not exist; predictor behaviour is identical.

Test Plan:
- Reset, then if_valid=1, if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044.
- Update upd_pc=0x40, taken, target 0x100; next cycle look up 0x40 -> pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x100.
- Saturation on PC 0x40:
  - Three more taken updates -> ctr=11.
  - One not-taken update -> ctr=10, still predicts 0x100.
  - Second not-taken update -> ctr=01, pred_taken=0, pred_target=0x44.
  - Further not-taken updates hold ctr at 00.
- Alias: with PC 0x40 installed, taken update for 0x440 (same index, different tag) -> entry replaced. Lookup 0x40 -> hit=0; lookup 0x440 -> hit=1, ctr=10.
- Collision: same-cycle lookup and first taken update of PC 0x80 -> lookup hit=0; next cycle hit=1. Not-taken update to empty index 0x90 -> no allocation, hit stays 0.
- BTP_STATS_EN:
  - 10 valid lookups with 4 hits and 2 mispredict updates -> stat_lookups=10, stat_hits=4, stat_mispredicts=2.
  - stat_clr -> all 0 next cycle.
  - Preload 0xFFFFFFFF + one lookup -> stat_lookups=0.
  - Assert rst mid-run -> counters and BTB cleared asynchronously.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup and EX update signals of the branch target predictor.
// master = pipeline side (IF/EX), slave = predictor.
interface branch_target_predictor_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;

    modport master (
        output if_valid, if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  if_valid, if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, registered update.
// Define BTP_STATS_EN to add lookup/hit/mispredict statistics counters.
module branch_target_predictor #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef BTP_STATS_EN
    input  logic                       stat_clr,
    output logic [31:0]                stat_lookups,
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_mispredicts,
`endif
    branch_target_predictor_if.slave   bus
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [ADDR_W-1:0]   target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic                upd_hit;
    logic                wr_en;
    logic [TAG_BITS-1:0] wr_tag;
    logic [ADDR_W-1:0]   wr_target;
    logic [1:0]          wr_ctr;

    assign if_idx  = bus.if_pc[IDX_BITS+1:2];
    assign if_tag  = bus.if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_idx = bus.upd_pc[IDX_BITS+1:2];
    assign upd_tag = bus.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // Lookup reads the stored entry directly, so a same-cycle update is not visible.
    always_comb begin
        bus.pred_hit    = bus.if_valid && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        bus.pred_taken  = bus.pred_hit && ctr_q[if_idx][1];
        bus.pred_target = bus.pred_taken ? target_q[if_idx] : bus.if_pc + ADDR_W'(4);
    end

    always_comb begin
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        wr_en     = 1'b0;
        wr_tag    = tag_q[upd_idx];
        wr_target = target_q[upd_idx];
        wr_ctr    = ctr_q[upd_idx];
        if (bus.upd_en) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (bus.upd_taken) begin
                    wr_ctr    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    wr_target = bus.upd_target;
                end else begin
                    wr_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                // Not-taken misses never allocate.
                wr_en     = 1'b1;
                wr_tag    = upd_tag;
                wr_target = bus.upd_target;
                wr_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= wr_tag;
            target_q[upd_idx] <= wr_target;
            ctr_q[upd_idx]    <= wr_ctr;
        end
    end

`ifdef BTP_STATS_EN
    logic [31:0] lookups_q, hits_q, mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else if (stat_clr) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            lookups_q     <= lookups_q + 32'(bus.if_valid);
            hits_q        <= hits_q + 32'(bus.pred_hit);
            mispredicts_q <= mispredicts_q + 32'(bus.upd_en && bus.upd_mispredict);
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispredicts_q;

    logic unused_bits;
    assign unused_bits = ^{bus.if_pc[1:0], bus.if_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2],
                           bus.upd_pc[1:0], bus.upd_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.if_pc[1:0], bus.if_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2],
                           bus.upd_pc[1:0], bus.upd_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2],
                           bus.upd_mispredict};
`endif
endmodule
